video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Parametrised, multi-mode successor to the video test-data stage.
- Sits between vgaReceiver and dviTransmitter on the video clock domain.
- Passes received pixels through, or replaces them with one of several generated patterns: colour bars, checkerboard, gradient, solid colour, moving bar.
- Tracks the pixel position within the frame, switches mode only at frame boundaries, and flags malformed frames.

Parameters:
- DATA_WIDTH, 8, bits per colour channel.
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- CHECKER_LOG2, 5, checker square edge is 2^CHECKER_LOG2 pixels.
- BAR_WIDTH, 16, width of the moving bar in pixels.

Ports:
- iClk  in  1  video clock. Single clock; all logic on its rising edge.
- iRst  in  1  synchronous active-high reset.
- iPixelSync  in  1  one-cycle pulse coincident with pixel (0,0) of a frame.
- iPixelActive  in  1  high on every active-pixel cycle.
- iDataRed / iDataGreen / iDataBlue  in  DATA_WIDTH each  input pixel.
- iMode  in  3  requested pattern mode.
- iSolidRed / iSolidGreen / iSolidBlue  in  DATA_WIDTH each  colour for solid mode.
- oPixelSync  out  1  iPixelSync delayed 1 cycle.
- oPixelActive  out  1  iPixelActive delayed 1 cycle.
- oDataRed / oDataGreen / oDataBlue  out  DATA_WIDTH each  output pixel.
- oFrameCount  out  16  frames seen since reset; wraps modulo 2^16.
- oSyncError  out  1  one-cycle pulse when a frame is malformed.

Behaviour:

Reset:
- Every output is 0.
- Internal state is 0: x and y counters, latched mode, bar position, frame counter, frameComplete. The firstFrame flag is set to 1.

Latency and registering:
- Exactly 1 cycle, input to output, for data, sync and active.
- All outputs are registered.

Position tracking:
- Current pixel coordinates: xCur = 0 and yCur = 0 when iPixelSync = 1; otherwise xCur = xCnt and yCur = yCnt.
- On an active cycle:
  - If xCur < H_ACTIVE-1: xCnt = xCur+1, yCnt = yCur.
  - Otherwise: xCnt = 0.
    - If yCur < V_ACTIVE-1: yCnt = yCur+1.
    - Otherwise: yCnt = 0 (wrap) and frameComplete is set.
- Counters hold on inactive cycles.
- Sync resynchronises the counters even mid-line.
- Active pixels with no sync after reset are counted starting from (0,0).

Frame boundary, on each iPixelSync:
- Latch iMode as the mode for this pixel and the rest of the frame.
- oFrameCount += 1.
- Bar position: barPos = barPos+1, or 0 if barPos+1 >= H_ACTIVE.
- oSyncError:
  - Pulses (on the output cycle of the sync pixel) if firstFrame = 0 and frameComplete = 0.
  - The first sync after reset never errors.
- Afterwards: clear frameComplete and firstFrame.

iMode changes between syncs are ignored.

Pattern, using the latched mode (the new mode on the sync pixel itself); all-ones = FS:
- 0 passthrough: output = input.
- 1 colour bars:
  - Bar index = xCur / (H_ACTIVE/8), integer division, saturated at 7.
  - Implement with a segment counter, not a divider.
  - Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 0 or FS.
- 2 checkerboard: FS on all channels if xCur[CHECKER_LOG2] XOR yCur[CHECKER_LOG2] = 1, else 0.
- 3 gradient:
  - Red = xCur mod 2^DATA_WIDTH.
  - Green = yCur mod 2^DATA_WIDTH.
  - Blue = oFrameCount low DATA_WIDTH bits.
- 4 solid: iSolid* inputs, sampled every cycle.
- 5 moving bar:
  - FS on all channels for barPos <= xCur < barPos+BAR_WIDTH, clipped at the right edge with no wrap.
  - Otherwise grey: only the MSB set.
- 6, 7 reserved: behave as passthrough.

Inactive cycles:
- Output data = input data, unmodified, in every mode.
- Counters do not advance.

Simultaneous events:
- Sync on the last expected pixel of the previous frame is a sync: the counters restart, not wrap.

Reset mid-frame:
- Outputs go to 0 on the next cycle.
- The next sync is treated as the first sync, so no error.

Test Plan:
1. Reset, then mode 0, one full 800x600 frame of incrementing data -> output equals input delayed 1 cycle; oFrameCount = 1; no oSyncError.
2. Mode 1, one line -> pixels 0-99 = FS/FS/FS, pixel 100 = FS/FS/0, pixels 700-799 = 0/0/0.
3. Mode change 0->2 mid-frame -> output stays passthrough until the next sync. On the sync pixel the output is black (0,0). Pixel x=32, y=0 is FS.
4. Second sync issued after only 300 lines -> oSyncError pulses once, 1 cycle after the sync; counters restart at (0,0). A following complete frame produces no error.
5. Mode 5 over 3 frames -> bar starts at x = 1, 2, 3 respectively. With barPos = 790, the bar covers x = 790-799 only; pixel x=0 is grey 0x80.
6. Mode 4 with solid colour 0x12/0x34/0x56, including inactive cycles carrying 0xAA -> active output = 0x12/0x34/0x56; inactive output = 0xAA.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Video test-pattern stage: passes received pixels through or substitutes a generated
// pattern, tracking frame position and switching mode only on frame sync.
module video_pattern_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int CHECKER_LOG2 = 5,
  parameter int BAR_WIDTH    = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iPixelSync,
  input  logic                  iPixelActive,
  input  logic [DATA_WIDTH-1:0] iDataRed,
  input  logic [DATA_WIDTH-1:0] iDataGreen,
  input  logic [DATA_WIDTH-1:0] iDataBlue,
  input  logic [2:0]            iMode,
  input  logic [DATA_WIDTH-1:0] iSolidRed,
  input  logic [DATA_WIDTH-1:0] iSolidGreen,
  input  logic [DATA_WIDTH-1:0] iSolidBlue,
  output logic                  oPixelSync,
  output logic                  oPixelActive,
  output logic [DATA_WIDTH-1:0] oDataRed,
  output logic [DATA_WIDTH-1:0] oDataGreen,
  output logic [DATA_WIDTH-1:0] oDataBlue,
  output logic [15:0]           oFrameCount,
  output logic                  oSyncError
);
  localparam int XW0   = $clog2(H_ACTIVE + 1);
  localparam int YW0   = $clog2(V_ACTIVE + 1);
  localparam int XW    = (XW0 > CHECKER_LOG2) ? XW0 : CHECKER_LOG2 + 1;
  localparam int YW    = (YW0 > CHECKER_LOG2) ? YW0 : CHECKER_LOG2 + 1;
  localparam int SEG   = H_ACTIVE / 8;
  localparam int SEG_W = $clog2(SEG + 1);

  localparam logic [DATA_WIDTH-1:0] FS   = '1;
  localparam logic [DATA_WIDTH-1:0] GREY = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    M_PASS   = 3'd0,
    M_BARS   = 3'd1,
    M_CHECK  = 3'd2,
    M_GRAD   = 3'd3,
    M_SOLID  = 3'd4,
    M_MOVBAR = 3'd5
  } mode_t;

  logic [XW-1:0]    x_cnt, x_cur;
  logic [YW-1:0]    y_cnt, y_cur;
  logic [SEG_W-1:0] seg_cnt, seg_cnt_cur;
  logic [2:0]       seg_idx, seg_idx_cur;
  logic [2:0]       mode_q, mode_cur;
  logic [XW-1:0]    bar_pos, bar_cur;
  logic [31:0]      bar_inc;
  logic [15:0]      frame_cnt, frame_cur;
  logic             first_frame, frame_complete;
  logic             x_last, y_last, wrap, in_bar;
  logic [DATA_WIDTH-1:0] pat_r, pat_g, pat_b;

  // On the sync pixel every frame-scoped value takes its new-frame value combinationally,
  // so the sync pixel itself is rendered with the freshly latched mode and bar position.
  always_comb begin
    x_cur       = iPixelSync ? '0 : x_cnt;
    y_cur       = iPixelSync ? '0 : y_cnt;
    seg_cnt_cur = iPixelSync ? '0 : seg_cnt;
    seg_idx_cur = iPixelSync ? '0 : seg_idx;
    mode_cur    = iPixelSync ? iMode : mode_q;
    bar_inc     = 32'(bar_pos) + 32'd1;
    bar_cur     = bar_pos;
    if (iPixelSync)
      bar_cur = (bar_inc >= 32'(H_ACTIVE)) ? '0 : XW'(bar_inc);
    frame_cur = frame_cnt + 16'(iPixelSync);
    x_last    = 32'(x_cur) >= 32'(H_ACTIVE - 1);
    y_last    = 32'(y_cur) >= 32'(V_ACTIVE - 1);
    wrap      = iPixelActive && x_last && y_last;
    in_bar    = (32'(x_cur) >= 32'(bar_cur)) &&
                (32'(x_cur) < 32'(bar_cur) + 32'(BAR_WIDTH));
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      x_cnt          <= '0;
      y_cnt          <= '0;
      seg_cnt        <= '0;
      seg_idx        <= '0;
      mode_q         <= '0;
      bar_pos        <= '0;
      frame_cnt      <= '0;
      frame_complete <= 1'b0;
      first_frame    <= 1'b1;
    end else begin
      if (iPixelActive) begin
        if (!x_last) begin
          x_cnt <= x_cur + XW'(1);
          y_cnt <= y_cur;
          // Colour-bar segment tracking replaces an x / (H_ACTIVE/8) divider.
          if (seg_cnt_cur == SEG_W'(SEG - 1)) begin
            seg_cnt <= '0;
            seg_idx <= (seg_idx_cur == 3'd7) ? 3'd7 : seg_idx_cur + 3'd1;
          end else begin
            seg_cnt <= seg_cnt_cur + SEG_W'(1);
            seg_idx <= seg_idx_cur;
          end
        end else begin
          x_cnt   <= '0;
          seg_cnt <= '0;
          seg_idx <= '0;
          y_cnt   <= y_last ? '0 : y_cur + YW'(1);
        end
      end else if (iPixelSync) begin
        x_cnt   <= '0;
        y_cnt   <= '0;
        seg_cnt <= '0;
        seg_idx <= '0;
      end
      if (iPixelSync) begin
        mode_q         <= mode_cur;
        bar_pos        <= bar_cur;
        frame_cnt      <= frame_cur;
        first_frame    <= 1'b0;
        frame_complete <= wrap;
      end else if (wrap) begin
        frame_complete <= 1'b1;
      end
    end
  end

  always_comb begin
    pat_r = iDataRed;
    pat_g = iDataGreen;
    pat_b = iDataBlue;
    if (iPixelActive) begin
      case (mode_cur)
        M_BARS: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          pat_r = seg_idx_cur[1] ? '0 : FS;
          pat_g = seg_idx_cur[2] ? '0 : FS;
          pat_b = seg_idx_cur[0] ? '0 : FS;
        end
        M_CHECK: begin
          pat_r = (x_cur[CHECKER_LOG2] ^ y_cur[CHECKER_LOG2]) ? FS : '0;
          pat_g = pat_r;
          pat_b = pat_r;
        end
        M_GRAD: begin
          pat_r = DATA_WIDTH'(x_cur);
          pat_g = DATA_WIDTH'(y_cur);
          pat_b = DATA_WIDTH'(frame_cur);
        end
        M_SOLID: begin
          pat_r = iSolidRed;
          pat_g = iSolidGreen;
          pat_b = iSolidBlue;
        end
        M_MOVBAR: begin
          pat_r = in_bar ? FS : GREY;
          pat_g = pat_r;
          pat_b = pat_r;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oPixelSync   <= 1'b0;
      oPixelActive <= 1'b0;
      oDataRed     <= '0;
      oDataGreen   <= '0;
      oDataBlue    <= '0;
      oFrameCount  <= '0;
      oSyncError   <= 1'b0;
    end else begin
      oPixelSync   <= iPixelSync;
      oPixelActive <= iPixelActive;
      oDataRed     <= pat_r;
      oDataGreen   <= pat_g;
      oDataBlue    <= pat_b;
      oFrameCount  <= frame_cur;
      oSyncError   <= iPixelSync && !first_frame && !frame_complete;
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a reduced frame size; every cycle is compared
// against a frame-level reference model driven by randomized pixel data.
module tb_video_pattern_gen;
  localparam int DW = 8, H = 64, V = 4, CL = 3, BW = 5;
  localparam logic [DW-1:0] FS = '1;
  localparam logic [DW-1:0] GREY = 8'h80;

  logic iClk = 1'b0;
  logic iRst, iPixelSync, iPixelActive;
  logic [DW-1:0] iDataRed, iDataGreen, iDataBlue;
  logic [2:0] iMode;
  logic [DW-1:0] iSolidRed, iSolidGreen, iSolidBlue;
  logic oPixelSync, oPixelActive, oSyncError;
  logic [DW-1:0] oDataRed, oDataGreen, oDataBlue;
  logic [15:0] oFrameCount;

  video_pattern_gen #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V),
                      .CHECKER_LOG2(CL), .BAR_WIDTH(BW)) dut (
    .iClk(iClk), .iRst(iRst), .iPixelSync(iPixelSync), .iPixelActive(iPixelActive),
    .iDataRed(iDataRed), .iDataGreen(iDataGreen), .iDataBlue(iDataBlue),
    .iMode(iMode), .iSolidRed(iSolidRed), .iSolidGreen(iSolidGreen), .iSolidBlue(iSolidBlue),
    .oPixelSync(oPixelSync), .oPixelActive(oPixelActive),
    .oDataRed(oDataRed), .oDataGreen(oDataGreen), .oDataBlue(oDataBlue),
    .oFrameCount(oFrameCount), .oSyncError(oSyncError));

  always #5 iClk = ~iClk;

  int tests = 0, fails = 0;

  // reference model state
  int mx, my, mmode, mbar;
  logic [15:0] mfc;
  bit mfirst, mcomplete;
  bit blank_aa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mmode = 0; mbar = 0; mfc = '0; mfirst = 1; mcomplete = 0;
  endtask

  task automatic step(input bit sync, input bit act, input int mode);
    logic [DW-1:0] r, g, b, er, eg, eb;
    bit eerr;
    int xc, yc, idx;
    r = DW'($urandom); g = DW'($urandom); b = DW'($urandom);
    if (!act && blank_aa) begin r = 8'hAA; g = 8'hAA; b = 8'hAA; end
    iPixelSync = sync; iPixelActive = act; iMode = 3'(mode);
    iDataRed = r; iDataGreen = g; iDataBlue = b;
    xc = sync ? 0 : mx;
    yc = sync ? 0 : my;
    eerr = 0;
    if (sync) begin
      eerr = !mfirst && !mcomplete;
      mmode = mode;
      mfc = mfc + 16'd1;
      mbar = (mbar + 1 >= H) ? 0 : mbar + 1;
      mfirst = 0;
      mcomplete = 0;
    end
    er = r; eg = g; eb = b;
    if (act) begin
      case (mmode)
        1: begin
          idx = xc / (H / 8);
          if (idx > 7) idx = 7;
          er = (idx inside {0, 1, 4, 5}) ? FS : '0;
          eg = (idx inside {0, 1, 2, 3}) ? FS : '0;
          eb = (idx inside {0, 2, 4, 6}) ? FS : '0;
        end
        2: begin
          er = ((((xc >> CL) ^ (yc >> CL)) & 1) != 0) ? FS : '0;
          eg = er; eb = er;
        end
        3: begin er = DW'(xc % 256); eg = DW'(yc % 256); eb = mfc[DW-1:0]; end
        4: begin er = iSolidRed; eg = iSolidGreen; eb = iSolidBlue; end
        5: begin
          er = (xc >= mbar && xc < mbar + BW) ? FS : GREY;
          eg = er; eb = er;
        end
        default: ;
      endcase
      if (xc < H - 1) begin mx = xc + 1; my = yc; end
      else begin
        mx = 0;
        if (yc < V - 1) my = yc + 1;
        else begin my = 0; mcomplete = 1; end
      end
    end
    @(posedge iClk); #1;
    chk("sync", 32'(oPixelSync), 32'(sync));
    chk("active", 32'(oPixelActive), 32'(act));
    chk("red", 32'(oDataRed), 32'(er));
    chk("green", 32'(oDataGreen), 32'(eg));
    chk("blue", 32'(oDataBlue), 32'(eb));
    chk("frame_count", 32'(oFrameCount), 32'(mfc));
    chk("sync_error", 32'(oSyncError), 32'(eerr));
  endtask

  // lines of H pixels (last line last_len long) each followed by 3 blanking cycles;
  // iMode is scrambled after the sync to show mid-frame changes are ignored
  task automatic send_frame(input int lines, input int mode, input int last_len);
    int len;
    for (int y = 0; y < lines; y++) begin
      len = (y == lines - 1) ? last_len : H;
      for (int x = 0; x < len; x++)
        step(x == 0 && y == 0, 1'b1, (x == 0 && y == 0) ? mode : int'($urandom_range(0, 7)));
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, int'($urandom_range(0, 7)));
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      iRst = 1'b1;
      iPixelSync = 1'($urandom); iPixelActive = 1'($urandom); iMode = 3'($urandom);
      iDataRed = DW'($urandom); iDataGreen = DW'($urandom); iDataBlue = DW'($urandom);
      @(posedge iClk); #1;
      chk("rst_data", {8'(oDataRed), 8'(oDataGreen), 8'(oDataBlue), 8'd0}, 32'd0);
      chk("rst_ctrl", {oPixelSync, oPixelActive, oSyncError, oFrameCount}, 32'd0);
    end
    iRst = 1'b0;
    model_reset();
  endtask

  initial begin
    iRst = 1'b1; iPixelSync = 0; iPixelActive = 0; iMode = 0;
    iDataRed = 0; iDataGreen = 0; iDataBlue = 0;
    iSolidRed = 0; iSolidGreen = 0; iSolidBlue = 0;
    blank_aa = 0;
    model_reset();
    do_reset(3);

    send_frame(V, 0, H);                       // passthrough
    chk("fc_after_first", 32'(oFrameCount), 32'd1);
    send_frame(V, 1, H);                       // colour bars
    send_frame(V, 2, H);                       // checkerboard
    send_frame(V, 3, H);                       // gradient
    iSolidRed = 8'h12; iSolidGreen = 8'h34; iSolidBlue = 8'h56; blank_aa = 1;
    send_frame(V, 4, H);                       // solid with 0xAA blanking
    blank_aa = 0;
    iSolidRed = DW'($urandom); iSolidGreen = DW'($urandom); iSolidBlue = DW'($urandom);
    send_frame(V, 4, H);
    send_frame(V, 6, H);                       // reserved modes
    send_frame(V, 7, H);

    send_frame(2, 3, H);                       // short frame: next sync must error
    send_frame(V, 2, H);
    send_frame(V, 0, H - 1);                   // next sync lands on last expected pixel
    send_frame(V, 3, H);
    send_frame(V, 1, H);

    send_frame(2, 5, 10);                      // reset mid-frame: next sync is first
    do_reset(1);
    send_frame(V, 5, H);

    for (int f = 0; f < 68; f++) send_frame(V, 5, H);  // bar walks to the edge and wraps

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
